// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters, burst-granted.
// Build option FIFO_ARB_TAG_EN: replace the top IDW bits of each written word with the source index.

module fifo_write_arbiter_lane #(
  parameter int DATASIZE = 16
) (
  input  logic                sel_i,
  input  logic                busy_i,
  input  logic                wfull_i,
  input  logic                valid_i,
  input  logic [DATASIZE-1:0] data_i,
  output logic                ready_o,
  output logic [DATASIZE-1:0] data_o
);
  // Gated data lets the top OR-reduce lanes instead of building a wide mux.
  assign ready_o = busy_i & sel_i & valid_i & ~wfull_i;
  assign data_o  = (busy_i & sel_i) ? data_i : '0;
endmodule

module fifo_write_arbiter #(
  parameter int DATASIZE = 16,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic [DATASIZE-1:0]      wdata,
  output logic                     winc,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAXBURST+1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                    state_q, state_d;
  logic [NREQ-1:0]           grant_q, grant_d;
  logic [IDW-1:0]            gidx_q, gidx_d;
  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]             beat_cnt_q, beat_cnt_d;

  logic [NREQ-1:0][DATASIZE-1:0] lane_data;
  logic [DATASIZE-1:0]           sel_data;
  logic                          beat, last_g, cap;
  logic                          pick_any;
  logic [IDW-1:0]                pick_idx, cand;

  assign busy  = (state_q == BURST);
  assign grant = grant_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fifo_write_arbiter_lane #(.DATASIZE(DATASIZE)) u_lane (
      .sel_i   (grant_q[i]),
      .busy_i  (busy),
      .wfull_i (wfull),
      .valid_i (req_valid[i]),
      .data_i  (req_data[i*DATASIZE +: DATASIZE]),
      .ready_o (req_ready[i]),
      .data_o  (lane_data[i])
    );
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) sel_data |= lane_data[i];
  end

`ifdef FIFO_ARB_TAG_EN
  logic unused_tag_bits;
  assign unused_tag_bits = ^sel_data[DATASIZE-1 -: IDW];
  assign wdata = busy ? {gidx_q, sel_data[DATASIZE-IDW-1:0]} : '0;
`else
  assign wdata = sel_data;
`endif

  assign winc   = |req_ready;
  assign beat   = winc;
  assign last_g = req_last[gidx_q];
  assign cap    = (beat_cnt_q == CW'(MAXBURST-1));

  // Scan from farthest to nearest so the first valid at/after rr_ptr wins.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_valid[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d           = BURST;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          beat_cnt_d        = '0;
        end
      end
      BURST: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_g || cap) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = (gidx_q == IDW'(NREQ-1)) ? '0 : gidx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: behavioural requesters plus an in-order word scoreboard.
module tb_fifo_write_arbiter;
  localparam int DS = 16, NR = 4, MB = 8;

  logic              clk = 1'b0;
  logic              rst, wfull;
  logic [NR-1:0]     req_valid, req_last, req_ready, grant;
  logic [NR*DS-1:0]  req_data;
  logic [DS-1:0]     wdata;
  logic              winc, busy;

  fifo_write_arbiter #(.DATASIZE(DS), .NREQ(NR), .MAXBURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .wdata(wdata), .winc(winc), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_left[NR], pkt_len[NR], bidx[NR], seq[NR], got[NR];
  logic [DS-1:0] base[NR];
  logic          s_winc;
  logic [NR-1:0] s_ready, s_grant;
  logic [DS-1:0] s_wdata;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [DS-1:0] expw(input int g, input logic [DS-1:0] d);
`ifdef FIFO_ARB_TAG_EN
    return {2'(g), d[DS-3:0]};
`else
    return d;
`endif
  endfunction

  function automatic logic is_last(input int i);
    return (pkt_len[i] != 0 && bidx[i] == pkt_len[i]-1) || n_left[i] == 1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = n_left[i] > 0;
      req_last[i]           = is_last(i);
      req_data[i*DS +: DS]  = base[i] + DS'(seq[i]);
    end
  endtask

  task automatic load(input int i, input int n, input int pl, input logic [DS-1:0] b);
    n_left[i] = n; pkt_len[i] = pl; bidx[i] = 0; seq[i] = 0; got[i] = 0; base[i] = b;
    drive();
  endtask

  // One clock: sample/score at negedge, then advance requesters after the edge.
  task automatic step();
    int g;
    @(negedge clk);
    s_winc = winc; s_ready = req_ready; s_grant = grant; s_wdata = wdata;
    chk("ready_vs_grant", 32'(s_ready), s_winc ? 32'(s_grant) : 32'd0);
    if (s_grant == '0) chk("idle_wdata", 32'(s_wdata), 32'd0);
    if (s_winc) begin
      g = -1;
      for (int i = 0; i < NR; i++) if (s_grant[i]) g = i;
      if (g < 0) chk("winc_without_grant", 32'd0, 32'd1);
      else       chk("wdata", 32'(s_wdata), 32'(expw(g, base[g] + DS'(seq[g]))));
    end
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      if (s_ready[i] && n_left[i] > 0) begin
        bidx[i] = is_last(i) ? 0 : bidx[i] + 1;
        seq[i]++; got[i]++; n_left[i]--;
      end
    end
    drive();
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      done = (n_left[0] == 0 && n_left[1] == 0 && n_left[2] == 0 && n_left[3] == 0 && s_grant == '0);
      if (!done) step();
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    int cur, nb;
    int bursts[4];
    logic exp_w[11];
    logic found;

    rst = 1'b1; wfull = 1'b0; s_grant = '0;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < NR; i++) load(i, 4, 2, DS'(i * 16'h1000));

    // Reset with all requesters valid
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_grant", 32'(s_grant), 32'd0);
      chk("rst_winc", 32'(s_winc), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd0);
    end
    rst = 1'b0;
    step();
    chk("rel_grant", 32'(s_grant), 32'd0);
    chk("rel_winc", 32'(s_winc), 32'd0);
    chk("rel_ready", 32'(s_ready), 32'd0);

    // Round robin: two beats then one bubble per burst, order 0,1,2,3,0
    for (int c = 0; c < 15; c++) begin
      step();
      chk("rr_grant", 32'(s_grant), (c % 3 == 2) ? 32'd0 : (32'd1 << ((c / 3) % 4)));
      chk("rr_winc", 32'(s_winc), (c % 3 == 2) ? 32'd0 : 32'd1);
    end
    drain();
    for (int i = 0; i < NR; i++) chk("rr_count", 32'(got[i]), 32'd4);

    // Burst cap: 20 beats alone -> 8, 8, 4
    load(2, 20, 0, 16'h2000);
    cur = 0; nb = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (s_winc) cur++;
      else if (s_grant == '0 && cur > 0) begin
        if (nb < 4) bursts[nb] = cur;
        nb++; cur = 0;
      end
    end
    chk("cap_nbursts", 32'(nb), 32'd3);
    chk("cap_burst0", 32'(bursts[0]), 32'd8);
    chk("cap_burst1", 32'(bursts[1]), 32'd8);
    chk("cap_burst2", 32'(bursts[2]), 32'd4);
    chk("cap_count", 32'(got[2]), 32'd20);
    drain();

    // Tagged word from requester 3
    load(3, 1, 1, 16'h0ABC);
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      step();
      if (s_winc) begin
        found = 1'b1;
`ifdef FIFO_ARB_TAG_EN
        chk("tag_wdata", 32'(s_wdata), 32'h0000_CABC);
`else
        chk("tag_wdata", 32'(s_wdata), 32'h0000_0ABC);
`endif
      end
    end
    chk("tag_beat", 32'(found), 32'd1);
    drain();

    // Full backpressure: wfull for 3 cycles mid-burst on a 6-beat packet
    load(1, 6, 6, 16'h1100);
    exp_w = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 11; c++) begin
      wfull = (c >= 3 && c <= 5);
      step();
      chk("bp_winc", 32'(s_winc), 32'(exp_w[c]));
      chk("bp_ready", 32'(s_ready[1]), 32'(exp_w[c]));
      chk("bp_grant", 32'(s_grant), (c == 0 || c == 10) ? 32'd0 : 32'd2);
    end
    wfull = 1'b0;
    chk("bp_count", 32'(got[1]), 32'd6);
    drain();

    // Reset mid-burst after beat 3; round-robin pointer must restart at 0
    load(2, 8, 8, 16'h5000);
    for (int k = 0; k < 20 && got[2] < 3; k++) step();
    chk("mid_beats", 32'(got[2]), 32'd3);
    rst = 1'b1;
    step();
    step();
    chk("mid_grant", 32'(s_grant), 32'd0);
    chk("mid_winc", 32'(s_winc), 32'd0);
    chk("mid_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) load(i, 1, 1, DS'(16'h6000 + i * 16'h0100));
    step();
    chk("post_idle_grant", 32'(s_grant), 32'd0);
    step();
    chk("post_first_grant", 32'(s_grant), 32'd1);
    drain();
    for (int i = 0; i < NR; i++) chk("post_count", 32'(got[i]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
